// File: rtl/rx_sg_packer_reader_pkg.sv
// Shared helpers for the SG receive path: ceiling-log2 for parameter
// derivation and the field layout of one 128-bit SG element.
package rx_sg_packer_reader_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int WORD_W      = 32;
  localparam int SG_ADDR_LSB = 0;
  localparam int SG_ADDR_W   = 64;
  localparam int SG_LEN_LSB  = 64;
  localparam int SG_LEN_W    = 32;

endpackage

// File: rtl/fifo_packer_128.sv
// Packs 0-4 right-justified 32-bit words per cycle into full 128-bit words,
// oldest word in the low lane; a flush pushes out a zero-padded partial word.
module fifo_packer_128
  import rx_sg_packer_reader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data,
  input  logic [2:0]   en,
  input  logic         done,
  input  logic         err,
  input  logic         flush,
  output logic         flushed,
  output logic [127:0] packed_data,
  output logic         packed_wen,
  output logic         packed_done,
  output logic         packed_err
);

  logic [1:0]   cnt;
  logic [95:0]  residue;
  logic [2:0]   en_eff;
  logic [2:0]   total;
  logic [127:0] data_masked;
  logic [223:0] combined;
  logic         flush_now;

  always_comb begin
    en_eff      = en[2] ? 3'd4 : en;
    data_masked = '0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < en_eff) data_masked[WORD_W*i +: WORD_W] = data[WORD_W*i +: WORD_W];
    combined  = ({96'b0, data_masked} << {cnt, 5'b0}) | {128'b0, residue};
    total     = {1'b0, cnt} + en_eff;
    // Suppress a repeat pulse while the requester is still seeing FLUSHED.
    flush_now = flush && (en_eff == 3'd0) && !flushed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      residue     <= '0;
      packed_data <= '0;
      packed_wen  <= 1'b0;
      flushed     <= 1'b0;
      packed_done <= 1'b0;
      packed_err  <= 1'b0;
    end else begin
      packed_wen  <= 1'b0;
      flushed     <= 1'b0;
      packed_done <= done;
      packed_err  <= err;
      if (total >= 3'd4) begin
        packed_data <= combined[127:0];
        packed_wen  <= 1'b1;
        residue     <= combined[223:128];
        cnt         <= total[1:0];
      end else if (flush_now) begin
        flushed <= 1'b1;
        if (cnt != 2'd0) begin
          packed_data <= {32'b0, residue};
          packed_wen  <= 1'b1;
          residue     <= '0;
          cnt         <= '0;
        end
      end else begin
        residue <= combined[95:0];
        cnt     <= total[1:0];
      end
    end
  end

endmodule

// File: rtl/sg_list_reader_128.sv
// Unpacks each 128-bit FIFO entry into a one-deep SG element register
// (64-bit address, 32-bit length); the top 32 bits are reserved.
module sg_list_reader_128
  import rx_sg_packer_reader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] buf_data,
  input  logic         buf_empty,
  output logic         buf_ren,
  output logic         elem_valid,
  input  logic         elem_ren,
  output logic [63:0]  elem_addr,
  output logic [31:0]  elem_len
);

  logic unused_hi;

  assign unused_hi = ^buf_data[127:96];
  assign buf_ren   = !buf_empty && (!elem_valid || elem_ren);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_valid <= 1'b0;
      elem_addr  <= '0;
      elem_len   <= '0;
    end else if (buf_ren) begin
      elem_valid <= 1'b1;
      elem_addr  <= buf_data[SG_ADDR_LSB +: SG_ADDR_W];
      elem_len   <= buf_data[SG_LEN_LSB +: SG_LEN_W];
    end else if (elem_ren) begin
      elem_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into an empty FIFO is
// visible on rd_data in the same cycle so a consumer can take it directly.
module sync_fifo
  import rx_sg_packer_reader_pkg::*;
#(
  parameter  int C_WIDTH         = 128,
  parameter  int C_DEPTH         = 512,
  parameter  int C_PROVIDE_COUNT = 1,
  localparam int AW              = clog2(C_DEPTH),
  localparam int CW              = clog2(C_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [C_WIDTH-1:0] wr_data,
  output logic               full,
  input  logic               rd_en,
  output logic [C_WIDTH-1:0] rd_data,
  output logic               empty,
  output logic [CW-1:0]      count
);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      level;
  logic               stored_empty;
  logic               do_wr;
  logic               do_rd;
  logic               wr_mem;
  logic               rd_adv;

  assign stored_empty = (level == '0);
  assign full         = (level == CW'(C_DEPTH));
  assign empty        = stored_empty && !wr_en;
  assign rd_data      = stored_empty ? wr_data : mem[rd_ptr];
  assign do_wr        = wr_en && !full;
  assign do_rd        = rd_en && !empty;
  // A word read in the cycle it arrives at an empty FIFO never lands in memory.
  assign wr_mem       = do_wr && !(do_rd && stored_empty);
  assign rd_adv       = do_rd && !stored_empty;
  assign count        = (C_PROVIDE_COUNT != 0) ? level : '0;

  always_ff @(posedge clk)
    if (wr_mem) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_mem);
      rd_ptr <= rd_ptr + AW'(rd_adv);
      level  <= level + CW'(wr_mem) - CW'(rd_adv);
    end
  end

endmodule

// File: rtl/rx_sg_packer_reader.sv
// SG list receive path: word packer -> 128-bit FIFO -> SG element reader.
module rx_sg_packer_reader
  import rx_sg_packer_reader_pkg::*;
#(
  parameter  int C_DATA_WIDTH          = 128,
  parameter  int C_SG_FIFO_DEPTH       = 512,
  localparam int C_DATA_WORD_WIDTH     = clog2(C_DATA_WIDTH / 32 + 1),
  localparam int C_SG_FIFO_DEPTH_WIDTH = clog2((1 << clog2(C_SG_FIFO_DEPTH)) + 1)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [C_DATA_WIDTH-1:0]          DATA_IN,
  input  logic [C_DATA_WORD_WIDTH-1:0]     DATA_IN_EN,
  input  logic                             DATA_IN_DONE,
  input  logic                             DATA_IN_ERR,
  input  logic                             DATA_IN_FLUSH,
  output logic                             DATA_IN_FLUSHED,
  output logic                             PACKED_DONE,
  output logic                             PACKED_ERR,
  output logic                             FIFO_FULL,
  output logic [C_SG_FIFO_DEPTH_WIDTH-1:0] FIFO_COUNT,
  output logic                             SG_ELEM_VALID,
  output logic                             SG_ELEM_EMPTY,
  input  logic                             SG_ELEM_REN,
  output logic [63:0]                      SG_ELEM_ADDR,
  output logic [31:0]                      SG_ELEM_LEN
);

  logic [127:0] packed_data;
  logic         packed_wen;
  logic [127:0] buf_data;
  logic         buf_empty;
  logic         buf_ren;

  fifo_packer_128 packer (
    .clk         (CLK),
    .rst         (RST),
    .data        (DATA_IN),
    .en          (DATA_IN_EN),
    .done        (DATA_IN_DONE),
    .err         (DATA_IN_ERR),
    .flush       (DATA_IN_FLUSH),
    .flushed     (DATA_IN_FLUSHED),
    .packed_data (packed_data),
    .packed_wen  (packed_wen),
    .packed_done (PACKED_DONE),
    .packed_err  (PACKED_ERR)
  );

  sync_fifo #(
    .C_WIDTH         (C_DATA_WIDTH),
    .C_DEPTH         (1 << clog2(C_SG_FIFO_DEPTH)),
    .C_PROVIDE_COUNT (1)
  ) fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (packed_wen),
    .wr_data (packed_data),
    .full    (FIFO_FULL),
    .rd_en   (buf_ren),
    .rd_data (buf_data),
    .empty   (buf_empty),
    .count   (FIFO_COUNT)
  );

  sg_list_reader_128 reader (
    .clk        (CLK),
    .rst        (RST),
    .buf_data   (buf_data),
    .buf_empty  (buf_empty),
    .buf_ren    (buf_ren),
    .elem_valid (SG_ELEM_VALID),
    .elem_ren   (SG_ELEM_REN),
    .elem_addr  (SG_ELEM_ADDR),
    .elem_len   (SG_ELEM_LEN)
  );

  assign SG_ELEM_EMPTY = !SG_ELEM_VALID;

endmodule

// File: tb/tb_rx_sg_packer_reader.sv
// Directed bench for rx_sg_packer_reader with a word-queue reference for the mixed-traffic run.
module tb_rx_sg_packer_reader;

  logic         clk;
  logic         rst;
  logic [127:0] data_in;
  logic [2:0]   en;
  logic         done;
  logic         err;
  logic         flush;
  logic         flushed;
  logic         packed_done;
  logic         packed_err;
  logic         full;
  logic [9:0]   count;
  logic         valid;
  logic         empty;
  logic         ren;
  logic [63:0]  addr;
  logic [31:0]  len;

  int n_chk;
  int n_fail;

  rx_sg_packer_reader dut (
    .CLK             (clk),
    .RST             (rst),
    .DATA_IN         (data_in),
    .DATA_IN_EN      (en),
    .DATA_IN_DONE    (done),
    .DATA_IN_ERR     (err),
    .DATA_IN_FLUSH   (flush),
    .DATA_IN_FLUSHED (flushed),
    .PACKED_DONE     (packed_done),
    .PACKED_ERR      (packed_err),
    .FIFO_FULL       (full),
    .FIFO_COUNT      (count),
    .SG_ELEM_VALID   (valid),
    .SG_ELEM_EMPTY   (empty),
    .SG_ELEM_REN     (ren),
    .SG_ELEM_ADDR    (addr),
    .SG_ELEM_LEN     (len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input string tag, input logic [63:0] a, input logic [31:0] l);
    int k;
    k = 0;
    while (!valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, 128'(valid), 128'd1);
    chk({tag, "_addr"}, 128'(addr), 128'(a));
    chk({tag, "_len"}, 128'(len), 128'(l));
    ren = 1'b1;
    step();
    ren = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0]  wq [$];
  logic [127:0] pq [$];
  logic [127:0] exp_el;
  logic [2:0]   e;
  logic         r;
  int           mism;
  int           consumed;
  int           total;
  int           k;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    data_in = '0;
    en = '0;
    done = 1'b0;
    err = 1'b0;
    flush = 1'b0;
    ren = 1'b0;
    repeat (3) step();

    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_addr", 128'(addr), 128'd0);
    chk("rst_len", 128'(len), 128'd0);
    chk("rst_flushed", 128'(flushed), 128'd0);
    chk("rst_pdone", 128'(packed_done), 128'd0);
    rst = 1'b0;
    step();

    // Four words in one cycle reach the output two cycles later.
    en = 3'd4;
    data_in = {32'h0, 32'h100, 32'h0, 32'h1000};
    step();
    en = 3'd0;
    chk("lat_valid_c1", 128'(valid), 128'd0);
    step();
    chk("lat_valid_c2", 128'(valid), 128'd1);
    chk("lat_addr", 128'(addr), 128'h1000);
    chk("lat_len", 128'(len), 128'h100);
    chk("lat_count", 128'(count), 128'd0);
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("lat_after_ren", 128'(valid), 128'd0);
    chk("lat_empty", 128'(empty), 128'd1);

    done = 1'b1;
    step();
    done = 1'b0;
    err = 1'b1;
    chk("pdone_hi", 128'(packed_done), 128'd1);
    chk("perr_lo", 128'(packed_err), 128'd0);
    step();
    err = 1'b0;
    chk("pdone_lo", 128'(packed_done), 128'd0);
    chk("perr_hi", 128'(packed_err), 128'd1);
    step();
    chk("perr_lo2", 128'(packed_err), 128'd0);

    // EN=2 twice; garbage above the valid words must be masked.
    en = 3'd2;
    data_in = {64'hDEAD_BEEF_DEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    step();
    en = 3'd2;
    data_in = {64'hFFFF_FFFF_FFFF_FFFF, 32'h4444_4444, 32'h3333_3333};
    step();
    en = 3'd0;
    pop("en2x2", 64'h2222_2222_1111_1111, 32'h3333_3333);

    // EN=3 twice leaves two words of residue; flush pushes them out.
    en = 3'd3;
    data_in = {32'hFFFF_FFFF, 32'hA2, 32'hA1, 32'hA0};
    step();
    en = 3'd3;
    data_in = {32'hFFFF_FFFF, 32'hA5, 32'hA4, 32'hA3};
    step();
    en = 3'd0;
    flush = 1'b1;
    step();
    chk("en3x2_flushed", 128'(flushed), 128'd1);
    flush = 1'b0;
    step();
    chk("en3x2_flushed_lo", 128'(flushed), 128'd0);
    chk("en3x2_count", 128'(count), 128'd1);
    pop("en3x2_e1", 64'h0000_00A1_0000_00A0, 32'hA2);
    pop("en3x2_e2", 64'h0000_00A5_0000_00A4, 32'h0);

    // Flush with nothing buffered: pulse only, no write.
    flush = 1'b1;
    step();
    chk("flush0_pulse", 128'(flushed), 128'd1);
    flush = 1'b0;
    step();
    chk("flush0_lo", 128'(flushed), 128'd0);
    chk("flush0_valid", 128'(valid), 128'd0);
    chk("flush0_count", 128'(count), 128'd0);

    en = 3'd1;
    data_in = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hAA};
    step();
    en = 3'd0;
    flush = 1'b1;
    step();
    chk("flushaa_pulse", 128'(flushed), 128'd1);
    flush = 1'b0;
    pop("flushaa", 64'hAA, 32'h0);
    chk("flushaa_once", 128'(flushed), 128'd0);
    chk("flushaa_drained", 128'(valid), 128'd0);

    // Flush held while words still arrive waits for an idle cycle.
    en = 3'd1;
    data_in = {96'h0, 32'hEE};
    flush = 1'b1;
    step();
    en = 3'd0;
    chk("flushwait_lo", 128'(flushed), 128'd0);
    step();
    chk("flushwait_hi", 128'(flushed), 128'd1);
    flush = 1'b0;
    pop("flushwait", 64'hEE, 32'h0);

    en = 3'd7;
    data_in = {32'h0, 32'h77, 32'h76, 32'h75};
    step();
    en = 3'd0;
    step();
    chk("en7_valid", 128'(valid), 128'd1);
    pop("en7", 64'h0000_0076_0000_0075, 32'h77);

    // Fill: element 1 sits in the reader, 2..513 fill the FIFO, 514 is dropped.
    for (int i = 1; i <= 514; i++) begin
      en = 3'd4;
      data_in = {32'h0, 32'(i), 32'h0, 32'(i)};
      step();
    end
    en = 3'd0;
    step();
    step();
    chk("fill_full", 128'(full), 128'd1);
    chk("fill_count", 128'(count), 128'd512);
    chk("fill_head", 128'(addr), 128'd1);
    mism = 0;
    ren = 1'b1;
    for (int i = 1; i <= 513; i++) begin
      if (!valid || addr !== 64'(i) || len !== 32'(i)) mism++;
      step();
    end
    ren = 1'b0;
    chk("fill_drain_mism", 128'(mism), 128'd0);
    chk("fill_drain_valid", 128'(valid), 128'd0);
    chk("fill_drain_count", 128'(count), 128'd0);
    chk("fill_drain_full", 128'(full), 128'd0);

    // Mixed traffic against a word-queue reference.
    mism = 0;
    consumed = 0;
    total = 0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 3) != 0);
      if (valid && r) begin
        if (pq.size() == 0) mism++;
        else begin
          exp_el = pq.pop_front();
          if (addr !== exp_el[63:0] || len !== exp_el[95:64]) mism++;
          consumed++;
        end
      end
      ren = r;
      e = 3'($urandom_range(0, 4));
      data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      done = 1'($urandom_range(0, 1));
      en = e;
      for (int i = 0; i < 4; i++)
        if (i < int'(e)) wq.push_back(data_in[32*i +: 32]);
      while (wq.size() >= 4) begin
        pq.push_back({wq[3], wq[2], wq[1], wq[0]});
        repeat (4) void'(wq.pop_front());
        total++;
      end
      step();
    end
    en = 3'd0;
    done = 1'b0;
    ren = 1'b1;
    k = 0;
    while (pq.size() > 0 && k < 3000) begin
      if (valid) begin
        exp_el = pq.pop_front();
        if (addr !== exp_el[63:0] || len !== exp_el[95:64]) mism++;
        consumed++;
      end
      step();
      k++;
    end
    ren = 1'b0;
    chk("rand_mism", 128'(mism), 128'd0);
    chk("rand_consumed", 128'(consumed), 128'(total));
    chk("rand_leftover", 128'(pq.size()), 128'd0);
    step();
    chk("rand_no_dup", 128'(valid), 128'd0);

    // Reset mid-stream clears everything without waiting for a clock edge.
    for (int i = 0; i < 3; i++) begin
      en = 3'd4;
      data_in = {32'h0, 32'h5000 + 32'(i), 32'h0, 32'h5000 + 32'(i)};
      step();
    end
    en = 3'd2;
    data_in = {64'h0, 32'hBAD1, 32'hBAD0};
    step();
    en = 3'd0;
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(valid), 128'd0);
    chk("arst_addr", 128'(addr), 128'd0);
    chk("arst_len", 128'(len), 128'd0);
    chk("arst_count", 128'(count), 128'd0);
    step();
    rst = 1'b0;
    step();
    en = 3'd2;
    data_in = {64'h0, 32'hC1, 32'hC0};
    step();
    en = 3'd2;
    data_in = {64'h0, 32'hC3, 32'hC2};
    step();
    en = 3'd0;
    pop("post_rst", 64'h0000_00C1_0000_00C0, 32'hC2);
    chk("post_rst_empty", 128'(valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
